vga_grid_renderer: RTL and testbench
====================================

Name: vga_grid_renderer

Overview:
- Pixel stage directly downstream of the 640x480 VGA timing generator.
- Consumes its pix_en-qualified hsync/vsync/x/y/visible stream and maps each pixel to a cell of a ROWS x COLS game board.
- Fetches the cell state from an external synchronous board RAM and drives 8-bit RGB plus delayed sync/blank to the DAC.
- Adds a blinking cursor cell and a per-frame tick for the game logic.

Parameters:
- COLS, 7, board columns (1..15)
- ROWS, 6, board rows (1..15)
- CELL_W, 64, cell width in pixels (>=2)
- CELL_H, 64, cell height in pixels (>=2)
- X0, 96, left pixel of grid; X0 + COLS*CELL_W <= 640
- Y0, 48, top line of grid; Y0 + ROWS*CELL_H <= 480
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous reset, active-low
- pix_en  in  1  pixel enable, one clk pulse per pixel, never two consecutive clks
- hsync_in  in  1  timing hsync, active-low
- vsync_in  in  1  timing vsync, active-low
- x  in  10  timing pixel column
- y  in  10  timing line
- visible  in  1  timing active-video flag
- cursor_col  in  4  cursor column
- cursor_row  in  4  cursor row
- cursor_en  in  1  enable cursor highlight
- cell_addr  out  8  board RAM address = row*COLS + col
- cell_data  in  2  board RAM read data, valid 1 clk after cell_addr changes
- hsync  out  1  delayed hsync
- vsync  out  1  delayed vsync
- blank_n  out  1  delayed visible
- r, g, b  out  8 each  pixel colour
- frame_tick  out  1  one-clk pulse per frame

Behaviour:
- Reset (rst==0 at a clk edge):
  - hsync=1, vsync=1, blank_n=0, r=g=b=0, cell_addr=0, frame_tick=0.
  - All counters cleared; blink phase = 0.
- Pipeline: two stages, advanced only on clk edges with pix_en=1. Outputs lag inputs by exactly 2 pix_en pulses. hsync/vsync/visible are delayed through both stages unchanged.
- Stage 1: cell tracking by incremental counters, no dividers.
  - col_idx/x_off: on pix_en with x==X0, load 0/0. Otherwise inside the grid, if x_off==CELL_W-1 then x_off=0 and col_idx++; else x_off++.
  - row_idx/y_off: updated on pix_en with x==0, using the same rule against y==Y0 and CELL_H.
  - in_grid = visible && X0<=x<X0+COLS*CELL_W && Y0<=y<Y0+ROWS*CELL_H.
  - cell_addr is registered = row_idx*COLS + col_idx and held outside the grid (no spurious toggling is required, only stability).
  - Registered along with it: in_grid, is_cursor = cursor_en && col/row match.
- Stage 2: sample cell_data (RAM latency 1 clk < pix_en period). Colour select, in priority order:
  - blank_n=0 -> 000000
  - !in_grid -> 202020
  - is_cursor && blink phase=1 -> FFFFFF
  - cell_data 0 -> 0040C0 (empty)
  - 1 -> FF0000
  - 2 -> FFD000
  - 3 -> 00C000
- Frame tick / blink:
  - frame_tick = 1 for one clk on the pix_en edge where x==0 && y==0.
  - Frame counter 0..BLINK_FRAMES-1; on wrap, blink phase toggles.
- cursor_col/row out of range: no cell matches; no highlight.
- Inputs are sampled every pix_en; a cursor change takes effect at the next pixel, not at frame boundary.
- Reset mid-frame: outputs return to reset values at once. The pipeline refills after 2 pix_en; cell counters resync at the next x==X0 / y==Y0.

Optional Feature:
- Macro GRID_LINES_EN.
- Defined: pixels with x_off==0 or y_off==0 inside the grid, plus the right/bottom border pixel, render 000000 ahead of cell/cursor colours (not ahead of blank).
- Undefined: no lines; cells fill completely.

Test Plan:
1. rst=0 for 4 clks with pix_en toggling -> hsync=vsync=1, blank_n=0, rgb=0, frame_tick=0; release -> first valid pixel appears 2 pix_en later.
2. Full frame, RAM model all cells=0 -> pixel (96,48) and (543,431) = 0040C0; (95,48), (544,48) = 202020; sync/blank outputs are exact input copies shifted 2 pix_en.
3. RAM cell addr 13 (row1,col6)=1, addr 41=2 -> pixels (480,112)=FF0000, (479,112)=0040C0, (480,400)=FFD000; cell_addr==13 while x in 480..543, y in 112..175.
4. cursor_en=1, cursor (3,2), BLINK_FRAMES=2 -> cell pixels FFFFFF during frames 2-3, normal colour in frames 0-1 and 4-5; cursor (15,15) -> never white.
5. Reset asserted at y=200 mid-line -> outputs at reset values next clk; after release, frame_tick pulses exactly once at the next (0,0) and colours correct on the following full frame.
6. GRID_LINES_EN defined -> (96,60), (160,60), (100,112) = 000000; (97,49) = cell colour; undefined -> (160,60) = cell colour.

Source files
------------

// File: rtl/vga_grid_renderer.sv
// VGA grid renderer: maps the pix_en-qualified timing stream onto a ROWS x COLS
// board, fetches each cell from a synchronous board RAM and drives RGB plus
// delayed sync/blank two pixels behind the timing inputs. Also produces a
// blinking cursor highlight and a per-frame tick.
// Optional feature: define GRID_LINES_EN to draw black cell borders.
module vga_grid_renderer #(
  parameter int COLS         = 7,
  parameter int ROWS         = 6,
  parameter int CELL_W       = 64,
  parameter int CELL_H       = 64,
  parameter int X0           = 96,
  parameter int Y0           = 48,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       visible,
  input  logic [3:0] cursor_col,
  input  logic [3:0] cursor_row,
  input  logic       cursor_en,
  output logic [7:0] cell_addr,
  input  logic [1:0] cell_data,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       frame_tick
);

  localparam int XW = $clog2(CELL_W);
  localparam int YW = $clog2(CELL_H);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0] X_BEG = 10'(X0);
  localparam logic [9:0] X_END = 10'(X0 + COLS * CELL_W);
  localparam logic [9:0] Y_BEG = 10'(Y0);
  localparam logic [9:0] Y_END = 10'(Y0 + ROWS * CELL_H);

  localparam logic [23:0] RGB_BORDER = 24'h202020;
  localparam logic [23:0] RGB_CURSOR = 24'hFFFFFF;
  localparam logic [23:0] RGB_EMPTY  = 24'h0040C0;
  localparam logic [23:0] RGB_RED    = 24'hFF0000;
  localparam logic [23:0] RGB_YELLOW = 24'hFFD000;
  localparam logic [23:0] RGB_GREEN  = 24'h00C000;

  // Stage-1 state: cell tracking counters and registered pixel attributes.
  logic [3:0]    col_q, col_d, row_q, row_d;
  logic [XW-1:0] xoff_q, xoff_d;
  logic [YW-1:0] yoff_q, yoff_d;
  logic [7:0]    addr_q, addr_d;
  logic          hs1_q, vs1_q, vis1_q;
  logic          in_grid_q, in_grid_d;
  logic          cursor_q, cursor_d;
  logic          line_q, line_d;

  // Frame tick and blink state.
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic          tick_q, tick_d;

  // Stage-2 (output) state.
  logic          hsync_q, vsync_q, blank_q;
  logic [23:0]   rgb_q, rgb_d;

  // Stage 1 next state: incremental column/row tracking and cell attributes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    col_d  = col_q;
    xoff_d = xoff_q;
    row_d  = row_q;
    yoff_d = yoff_q;
    addr_d = addr_q;

    if (x == X_BEG) begin
      col_d  = '0;
      xoff_d = '0;
    end else if (x > X_BEG && x < X_END) begin
      if (xoff_q == XW'(CELL_W - 1)) begin
        xoff_d = '0;
        col_d  = col_q + 4'd1;
      end else begin
        xoff_d = xoff_q + XW'(1);
      end
    end

    // Rows advance once per line, on the first pixel of the line.
    if (x == 10'd0) begin
      if (y == Y_BEG) begin
        row_d  = '0;
        yoff_d = '0;
      end else if (y > Y_BEG && y < Y_END) begin
        if (yoff_q == YW'(CELL_H - 1)) begin
          yoff_d = '0;
          row_d  = row_q + 4'd1;
        end else begin
          yoff_d = yoff_q + YW'(1);
        end
      end
    end

    in_grid_d = visible && (x >= X_BEG) && (x < X_END) && (y >= Y_BEG) && (y < Y_END);
    cursor_d  = cursor_en && (cursor_col == col_d) && (cursor_row == row_d);

    // The address is held outside the grid so the RAM port stays quiet.
    if (in_grid_d) begin
      addr_d = 8'(row_d) * 8'(COLS) + 8'(col_d);
    end

`ifdef GRID_LINES_EN
    line_d = (xoff_d == '0) || (yoff_d == '0) ||
             ((col_d == 4'(COLS - 1)) && (xoff_d == XW'(CELL_W - 1))) ||
             ((row_d == 4'(ROWS - 1)) && (yoff_d == YW'(CELL_H - 1)));
`else
    line_d = 1'b0;
`endif
  end

  // Stage 1 registers, advanced once per pixel.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      col_q     <= '0;
      row_q     <= '0;
      xoff_q    <= '0;
      yoff_q    <= '0;
      addr_q    <= '0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      vis1_q    <= 1'b0;
      in_grid_q <= 1'b0;
      cursor_q  <= 1'b0;
      line_q    <= 1'b0;
    end else if (pix_en) begin
      col_q     <= col_d;
      row_q     <= row_d;
      xoff_q    <= xoff_d;
      yoff_q    <= yoff_d;
      addr_q    <= addr_d;
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
      vis1_q    <= visible;
      in_grid_q <= in_grid_d;
      cursor_q  <= cursor_d;
      line_q    <= line_d;
    end
  end

  // Frame tick on the first pixel of a frame; blink phase flips every BLINK_FRAMES ticks.
  always_comb begin
    tick_d  = pix_en && (x == 10'd0) && (y == 10'd0);
    frame_d = frame_q;
    blink_d = blink_q;
    if (tick_d) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // Frame counter, blink phase and the one-clock tick pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_q <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
    end
  end

  // Stage 2 colour select in priority order.
  always_comb begin
    rgb_d = 24'h000000;
    if (!vis1_q) begin
      rgb_d = 24'h000000;
    end else if (!in_grid_q) begin
      rgb_d = RGB_BORDER;
    end else if (line_q) begin
      rgb_d = 24'h000000;
    end else if (cursor_q && blink_q) begin
      rgb_d = RGB_CURSOR;
    end else begin
      unique case (cell_data)
        2'd0: rgb_d = RGB_EMPTY;
        2'd1: rgb_d = RGB_RED;
        2'd2: rgb_d = RGB_YELLOW;
        2'd3: rgb_d = RGB_GREEN;
      endcase
    end
  end

  // Stage 2 registers: final colour and doubly delayed sync/blank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else if (pix_en) begin
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
      blank_q <= vis1_q;
      rgb_q   <= rgb_d;
    end
  end

  assign cell_addr  = addr_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign blank_n    = blank_q;
  assign r          = rgb_q[23:16];
  assign g          = rgb_q[15:8];
  assign b          = rgb_q[7:0];
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Scoreboard bench for vga_grid_renderer on a scaled-down raster (48x27 total,
// 40x24 visible) so many frames fit in a short run. Expected pixels come from
// a division/modulo model of the board; a monitor pops and compares them as
// the DUT presents each delayed pixel.
module tb_vga_grid_renderer;

  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CW    = 4;
  localparam int CH    = 3;
  localparam int GX0   = 6;
  localparam int GY0   = 3;
  localparam int BLINK = 2;

  localparam int H_VIS = 40, H_TOT = 48, HS_BEG = 42, HS_END = 46;
  localparam int V_VIS = 24, V_TOT = 27, VS_BEG = 25, VS_END = 26;

  logic       clk, rst, pix_en, hsync_in, vsync_in, visible, cursor_en;
  logic [9:0] x, y;
  logic [3:0] cursor_col, cursor_row;
  logic [7:0] cell_addr;
  logic [1:0] cell_data;
  logic       hsync, vsync, blank_n, frame_tick;
  logic [7:0] r, g, b;

  vga_grid_renderer #(
    .COLS(COLS), .ROWS(ROWS), .CELL_W(CW), .CELL_H(CH),
    .X0(GX0), .Y0(GY0), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .visible(visible), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .cursor_en(cursor_en), .cell_addr(cell_addr), .cell_data(cell_data),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .r(r), .g(g), .b(b),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM model: one clock read latency.
  logic [1:0] ram [256];
  always @(posedge clk) cell_data <= ram[cell_addr];

  typedef struct {
    int          px;
    int          py;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
    bit          chk_rgb;
    bit          chk_addr;
    logic [7:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   px, py, fr;
  int   frames_since_rst = 0;
  bit   synced = 0;
  bit   pe_edge = 0, rst_edge = 0, exp_tick = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] palette(input logic [1:0] s);
    case (s)
      2'd0:    return 24'h0040C0;
      2'd1:    return 24'hFF0000;
      2'd2:    return 24'hFFD000;
      default: return 24'h00C000;
    endcase
  endfunction

  // Reference pixel: board position by division, blink phase from frame count.
  function automatic exp_t model(input int xx, input int yy);
    exp_t e;
    int   col, row, xo, yo;
    bit   in_g, line;
    e.px = xx; e.py = yy;
    e.hs = hsync_in; e.vs = vsync_in; e.bl = visible;
    e.chk_rgb = 1; e.chk_addr = 0; e.addr = 8'd0;
    in_g = visible && xx >= GX0 && xx < GX0 + COLS * CW && yy >= GY0 && yy < GY0 + ROWS * CH;
    if (!visible) e.rgb = 24'h000000;
    else if (!in_g) e.rgb = 24'h202020;
    else begin
      col = (xx - GX0) / CW;  xo = (xx - GX0) % CW;
      row = (yy - GY0) / CH;  yo = (yy - GY0) % CH;
      e.addr = 8'(row * COLS + col);
      e.chk_rgb = synced;
      e.chk_addr = synced;
`ifdef GRID_LINES_EN
      line = (xo == 0) || (yo == 0) || (xx == GX0 + COLS * CW - 1) || (yy == GY0 + ROWS * CH - 1);
`else
      line = 0;
`endif
      if (line) e.rgb = 24'h000000;
      else if (cursor_en && int'(cursor_col) == col && int'(cursor_row) == row &&
               ((frames_since_rst / BLINK) % 2) == 1)
        e.rgb = 24'hFFFFFF;
      else e.rgb = palette(ram[row * COLS + col]);
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: record what the DUT samples at each edge.
  initial forever begin
    @(posedge clk);
    pe_edge  = pix_en;
    rst_edge = rst;
    if (!rst) begin
      sb.delete();
      frames_since_rst = 0;
      synced = 0;
      exp_tick = 0;
    end else begin
      exp_tick = pix_en && x == 10'd0 && y == 10'd0;
      if (pix_en) begin
        if (exp_tick) begin
          frames_since_rst++;
          synced = 1;
        end
        sb.push_back(model(int'(x), int'(y)));
      end
    end
  end

  // Monitor: compare presented outputs half a clock after each edge.
  initial forever begin
    exp_t e, n;
    @(negedge clk);
    check("frame_tick", 32'(frame_tick), 32'(exp_tick));
    if (!rst_edge) begin
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_blank_n", 32'(blank_n), 32'd0);
      check("rst_rgb", 32'({r, g, b}), 32'd0);
      check("rst_cell_addr", 32'(cell_addr), 32'd0);
    end else if (pe_edge) begin
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        check($sformatf("hsync@(%0d,%0d)", e.px, e.py), 32'(hsync), 32'(e.hs));
        check($sformatf("vsync@(%0d,%0d)", e.px, e.py), 32'(vsync), 32'(e.vs));
        check($sformatf("blank_n@(%0d,%0d)", e.px, e.py), 32'(blank_n), 32'(e.bl));
        if (e.chk_rgb)
          check($sformatf("rgb@(%0d,%0d)", e.px, e.py), 32'({r, g, b}), 32'(e.rgb));
        n = sb[0];
        if (n.chk_addr)
          check($sformatf("cell_addr@(%0d,%0d)", n.px, n.py), 32'(cell_addr), 32'(n.addr));
      end else begin
        // Pipeline still holds reset contents one pixel after release.
        check("refill_hsync", 32'(hsync), 32'd1);
        check("refill_vsync", 32'(vsync), 32'd1);
        check("refill_blank_n", 32'(blank_n), 32'd0);
        check("refill_rgb", 32'({r, g, b}), 32'd0);
      end
    end
  end

  task automatic drive_pixel();
    x        = 10'(px);
    y        = 10'(py);
    visible  = (px < H_VIS) && (py < V_VIS);
    hsync_in = !(px >= HS_BEG && px < HS_END);
    vsync_in = !(py >= VS_BEG && py < VS_END);
    pix_en   = 1'b1;
    @(negedge clk);
    pix_en   = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    px++;
    if (px == H_TOT) begin
      px = 0;
      py++;
      if (py == V_TOT) begin
        py = 0;
        fr++;
      end
    end
  endtask

  // Board contents change only in vertical blanking, between frames.
  task automatic update_ram();
    if (fr == 1) begin
      ram[13] = 2'd1;
      ram[41] = 2'd2;
    end else if (fr >= 2) begin
      for (int i = 0; i < ROWS * COLS; i++) ram[i] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic update_cursor();
    if (fr >= 1 && fr <= 4) begin
      cursor_en = 1'b1; cursor_col = 4'd3; cursor_row = 4'd2;
    end else if (fr == 6) begin
      cursor_en = 1'b1; cursor_col = 4'd15; cursor_row = 4'd15;
    end else if ($urandom_range(0, 31) == 0) begin
      cursor_en  = ($urandom_range(0, 3) != 0);
      cursor_col = 4'($urandom_range(0, 9));
      cursor_row = 4'($urandom_range(0, 7));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 2'd0;
    rst = 1'b0; pix_en = 1'b0; x = '0; y = '0; visible = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    px = 0; py = V_TOT - 2; fr = 0;
    @(negedge clk);
    repeat (2) drive_pixel();
    rst = 1'b1;
    while (fr < 12) begin
      if (px == 0 && py == V_VIS) update_ram();
      update_cursor();
      if (fr == 8 && py == 12 && px == 15) begin
        rst = 1'b0;
        repeat (2) drive_pixel();
        rst = 1'b1;
      end
      drive_pixel();
    end
    repeat (4) drive_pixel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
